data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arbiter_pkg.sv | 35 +++
 rtl/data_bus_arbiter_if.sv | 60 ++++++
 rtl/data_bus_arbiter_rr_pick2.sv | 30 +++
 rtl/data_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : data_bus_arbiter_pkg
// Brief    : Shared FSM states, access-size codes and master indices for the
//            DataBusControl arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic MST_CORE = 1'b0;
    localparam logic MST_EXT  = 1'b1;

    // Wait-counter width: enough bits to hold the limit, clamped to 8..16.
    function automatic int timeout_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : data_bus_arbiter_if
// Brief     : Two requester ports (M0 core, M1 loader/debug) plus the shared
//             DataBusControl port. slave = arbiter view, master = environment.
// Revision  : 1.0 - initial release
// ============================================================================
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [1:0]            m0_size;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_done;
    logic                  m0_err;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [1:0]            m1_size;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_done;
    logic                  m1_err;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  bus_ready;
    logic                  bus_busy;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_wd;
    logic                  bus_rd;
    logic [1:0]            bus_size;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;

    modport slave (
        input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_err, m1_rdata,
        input  bus_ready, bus_busy, bus_rdata,
        output bus_wd, bus_rd, bus_size, bus_addr, bus_wdata
    );

    modport master (
        output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_err, m0_rdata,
        output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_err, m1_rdata,
        output bus_ready, bus_busy, bus_rdata,
        input  bus_wd, bus_rd, bus_size, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter_rr_pick2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational 2-way round-robin pick. A lone requester wins;
//            on a tie the master that was not served last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Resolve the winner from the request pair and the last-served master.
    always_comb begin
        valid  = |req;
        winner = MST_CORE;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = MST_EXT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Brief    : Shares the DataBusControl port between M0 and M1 with round-robin
//            priority: latch winner, strobe, wait for idle, return data/done.
// Options  : RISCUIN_BUS_TIMEOUT_EN - abort a WAIT after TIMEOUT_CYCLES with err
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    data_bus_arbiter_if.slave  dbus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("data_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                          r_state, w_state_nxt;
    logic                            r_owner, w_owner_nxt;
    logic                            r_last, w_last_nxt;
    logic                            r_we, w_we_nxt;
    logic [1:0]                      r_size, w_size_nxt;
    logic [ADDR_WIDTH-1:0]           r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]           r_wdata, w_wdata_nxt;
    logic                            r_wd, w_wd_nxt;
    logic                            r_rd, w_rd_nxt;
    logic [1:0]                      r_gnt, w_gnt_nxt;
    logic [1:0]                      r_done, w_done_nxt;
    logic [1:0][DATA_WIDTH-1:0]      r_rdata, w_rdata_nxt;
    logic                            w_pick_valid;
    logic                            w_pick_winner;

    rr_pick2 u_pick (
        .req    ({dbus.m1_req, dbus.m0_req}),
        .last   (r_last),
        .valid  (w_pick_valid),
        .winner (w_pick_winner)
    );

`ifdef RISCUIN_BUS_TIMEOUT_EN
    localparam int              TO_W    = timeout_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            w_timeout_hit;
    logic [1:0]      r_err, w_err_nxt;

    // Count WAIT cycles; held at zero outside WAIT so each WAIT starts fresh.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end
    end

    assign w_timeout_hit = (r_wait_cnt == TO_LAST);
    assign dbus.m0_err   = r_err[0];
    assign dbus.m1_err   = r_err[1];
`else
    assign dbus.m0_err   = 1'b0;
    assign dbus.m1_err   = 1'b0;
`endif

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that every port is driven straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_we_nxt    = r_we;
        w_size_nxt  = r_size;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_wd_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
        w_gnt_nxt   = 2'b00;
        w_done_nxt  = 2'b00;
        w_rdata_nxt = '0;
`ifdef RISCUIN_BUS_TIMEOUT_EN
        w_err_nxt   = 2'b00;
`endif
        case (r_state)
            ST_IDLE: begin
                if (dbus.bus_ready && w_pick_valid) begin
                    w_state_nxt              = ST_ISSUE;
                    w_owner_nxt              = w_pick_winner;
                    w_we_nxt                 = w_pick_winner ? dbus.m1_we    : dbus.m0_we;
                    w_size_nxt               = w_pick_winner ? dbus.m1_size  : dbus.m0_size;
                    w_addr_nxt               = w_pick_winner ? dbus.m1_addr  : dbus.m0_addr;
                    w_wdata_nxt              = w_pick_winner ? dbus.m1_wdata : dbus.m0_wdata;
                    w_gnt_nxt[w_pick_winner] = 1'b1;
                    w_wd_nxt                 = w_we_nxt;
                    w_rd_nxt                 = ~w_we_nxt;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!dbus.bus_busy && dbus.bus_ready) begin
                    w_state_nxt          = ST_DONE;
                    w_done_nxt[r_owner]  = 1'b1;
                    w_rdata_nxt[r_owner] = r_we ? '0 : dbus.bus_rdata;
                end
`ifdef RISCUIN_BUS_TIMEOUT_EN
                else if (dbus.bus_busy && w_timeout_hit) begin
                    w_state_nxt         = ST_DONE;
                    w_done_nxt[r_owner] = 1'b1;
                    w_err_nxt[r_owner]  = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                w_last_nxt  = r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered ownership, latched request fields and all port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= MST_CORE;
            r_last  <= MST_EXT;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wd    <= 1'b0;
            r_rd    <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_rdata <= '0;
`ifdef RISCUIN_BUS_TIMEOUT_EN
            r_err   <= 2'b00;
`endif
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_we    <= w_we_nxt;
            r_size  <= w_size_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_wd    <= w_wd_nxt;
            r_rd    <= w_rd_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
`ifdef RISCUIN_BUS_TIMEOUT_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign dbus.m0_gnt    = r_gnt[0];
    assign dbus.m1_gnt    = r_gnt[1];
    assign dbus.m0_done   = r_done[0];
    assign dbus.m1_done   = r_done[1];
    assign dbus.m0_rdata  = r_rdata[0];
    assign dbus.m1_rdata  = r_rdata[1];
    assign dbus.bus_wd    = r_wd;
    assign dbus.bus_rd    = r_rd;
    assign dbus.bus_size  = r_size;
    assign dbus.bus_addr  = r_addr;
    assign dbus.bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Brief    : Self-checking bench for data_bus_arbiter with a simple bus model
//            and a completion scoreboard.
// Options  : RISCUIN_BUS_TIMEOUT_EN - selects the timeout expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    int   busy_len  = 0;
    int   busy_rem  = 0;
    logic bus_stuck = 1'b0;

    data_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dbus ();

    data_bus_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dbus (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return 32'hDEADBEFF ^ a;
    endfunction

    // Bus model: a strobe starts a transfer that stays busy for busy_len
    // further cycles (or forever while bus_stuck is set).
    always @(negedge clk) begin
        if (dbus.bus_rd || dbus.bus_wd) begin
            dbus.bus_busy  = 1'b1;
            busy_rem       = busy_len;
            dbus.bus_rdata = model_rdata(dbus.bus_addr);
        end else if (bus_stuck) begin
            dbus.bus_busy = 1'b1;
        end else if (busy_rem == 0) begin
            dbus.bus_busy = 1'b0;
        end else begin
            busy_rem = busy_rem - 1;
        end
    end

    task automatic wait_done(input int limit, output int cyc, output logic found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (dbus.m0_done || dbus.m1_done) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dbus.m1_gnt, dbus.m0_gnt, dbus.m1_done, dbus.m0_done, dbus.m1_err, dbus.m0_err, dbus.bus_wd, dbus.bus_rd} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000000", {dbus.m1_gnt, dbus.m0_gnt, dbus.m1_done, dbus.m0_done, dbus.m1_err, dbus.m0_err, dbus.bus_wd, dbus.bus_rd});
        end
        n_checks++;
        if (dbus.bus_addr !== 32'h0 || dbus.bus_wdata !== 32'h0 || dbus.bus_size !== 2'b00) begin
            n_fail++; $display("FAIL reset_bus: addr %h wdata %h size %b required all 0", dbus.bus_addr, dbus.bus_wdata, dbus.bus_size);
        end
        n_checks++;
        if (dbus.m0_rdata !== 32'h0 || dbus.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: m0 %h m1 %h required 0", dbus.m0_rdata, dbus.m1_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_m0_read();
        int cyc; logic found; exp_t e;
        busy_len = 2;
        dbus.m0_req = 1'b1; dbus.m0_we = 1'b0; dbus.m0_size = SZ_WORD;
        dbus.m0_addr = 32'h0000_0010; dbus.m0_wdata = 32'h0;
        sb.push_back('{mst: MST_CORE, rdata: 32'hDEADBEEF, err: 1'b0});
        @(negedge clk);
        n_checks++;
        if (dbus.m0_gnt !== 1'b1 || dbus.m1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rd_gnt: m0 %b m1 %b required 1 0", dbus.m0_gnt, dbus.m1_gnt);
        end
        n_checks++;
        if (dbus.bus_rd !== 1'b1 || dbus.bus_wd !== 1'b0 || dbus.bus_addr !== 32'h10 || dbus.bus_size !== SZ_WORD) begin
            n_fail++; $display("FAIL rd_issue: rd %b wd %b addr %h size %b required 1 0 00000010 10", dbus.bus_rd, dbus.bus_wd, dbus.bus_addr, dbus.bus_size);
        end
        dbus.m0_req = 1'b0; dbus.m0_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        n_checks++;
        if (dbus.bus_rd !== 1'b0 || dbus.bus_addr !== 32'h10 || dbus.m0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rd_wait: rd %b addr %h gnt %b required 0 00000010 0", dbus.bus_rd, dbus.bus_addr, dbus.m0_gnt);
        end
        wait_done(10, cyc, found);
        n_checks++;
        if (!found || cyc != 3) begin
            n_fail++; $display("FAIL rd_latency: done after %0d wait cycles (found %b) required 3", cyc, found);
        end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({dbus.m1_done, dbus.m0_done} !== (e.mst ? 2'b10 : 2'b01) || dbus.m0_rdata !== e.rdata || dbus.m0_err !== e.err || dbus.m1_rdata !== 32'h0) begin
                n_fail++; $display("FAIL rd_result: done %b rdata %h err %b required %b %h %b", {dbus.m1_done, dbus.m0_done}, dbus.m0_rdata, dbus.m0_err, (e.mst ? 2'b10 : 2'b01), e.rdata, e.err);
            end
        end
        @(negedge clk);
        n_checks++;
        if (dbus.m0_done !== 1'b0 || dbus.m0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_done_pulse: done %b rdata %h required 0 0", dbus.m0_done, dbus.m0_rdata);
        end
    endtask

    task automatic test_m1_write();
        int cyc; logic found; exp_t e;
        busy_len = 1;
        dbus.m1_req = 1'b1; dbus.m1_we = 1'b1; dbus.m1_size = SZ_BYTE;
        dbus.m1_addr = 32'h0000_0020; dbus.m1_wdata = 32'h1234_5678;
        sb.push_back('{mst: MST_EXT, rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        n_checks++;
        if (dbus.m1_gnt !== 1'b1 || dbus.m0_gnt !== 1'b0 || dbus.bus_wd !== 1'b1 || dbus.bus_rd !== 1'b0) begin
            n_fail++; $display("FAIL wr_issue: gnt %b%b wd %b rd %b required 10 1 0", dbus.m1_gnt, dbus.m0_gnt, dbus.bus_wd, dbus.bus_rd);
        end
        n_checks++;
        if (dbus.bus_wdata !== 32'h1234_5678 || dbus.bus_size !== SZ_BYTE || dbus.bus_addr !== 32'h20) begin
            n_fail++; $display("FAIL wr_fields: wdata %h size %b addr %h required 12345678 00 00000020", dbus.bus_wdata, dbus.bus_size, dbus.bus_addr);
        end
        dbus.m1_req = 1'b0; dbus.m1_wdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (dbus.bus_wd !== 1'b0 || dbus.bus_wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wr_hold: wd %b wdata %h required 0 12345678", dbus.bus_wd, dbus.bus_wdata);
        end
        wait_done(10, cyc, found);
        n_checks++;
        if (!found || cyc != 2) begin
            n_fail++; $display("FAIL wr_latency: done after %0d wait cycles (found %b) required 2", cyc, found);
        end
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({dbus.m1_done, dbus.m0_done} !== (e.mst ? 2'b10 : 2'b01) || dbus.m1_rdata !== e.rdata || dbus.m1_err !== e.err) begin
                n_fail++; $display("FAIL wr_result: done %b rdata %h err %b required %b %h %b", {dbus.m1_done, dbus.m0_done}, dbus.m1_rdata, dbus.m1_err, (e.mst ? 2'b10 : 2'b01), e.rdata, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] order = 4'b1010;
        int grants = 0; int dones = 0; int cyc = 0; exp_t e;
        busy_len = 1;
        dbus.m0_req = 1'b1; dbus.m0_we = 1'b0; dbus.m0_size = SZ_WORD; dbus.m0_addr = 32'h100;
        dbus.m1_req = 1'b1; dbus.m1_we = 1'b0; dbus.m1_size = SZ_HALF; dbus.m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (order[i]) sb.push_back('{mst: MST_EXT,  rdata: model_rdata(32'h200), err: 1'b0});
            else          sb.push_back('{mst: MST_CORE, rdata: model_rdata(32'h100), err: 1'b0});
        end
        while (dones < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (dbus.m0_gnt || dbus.m1_gnt) begin
                n_checks++;
                if (dbus.m0_gnt && dbus.m1_gnt) begin
                    n_fail++; $display("FAIL rr_double_gnt: both grants high in cycle %0d required one", cyc);
                end else if (dbus.m1_gnt !== order[grants % 4]) begin
                    n_fail++; $display("FAIL rr_owner: grant %0d went to M%0d required M%0d", grants, dbus.m1_gnt, order[grants % 4]);
                end
                grants++;
            end
            if (dbus.m0_done || dbus.m1_done) begin
                dones++;
                if (dones == 4) begin dbus.m0_req = 1'b0; dbus.m1_req = 1'b0; end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if ({dbus.m1_done, dbus.m0_done} !== (e.mst ? 2'b10 : 2'b01) || (e.mst ? dbus.m1_rdata : dbus.m0_rdata) !== e.rdata || (e.mst ? dbus.m0_rdata : dbus.m1_rdata) !== 32'h0) begin
                        n_fail++; $display("FAIL rr_result: done %b rdata m0 %h m1 %h required owner M%0d rdata %h", {dbus.m1_done, dbus.m0_done}, dbus.m0_rdata, dbus.m1_rdata, e.mst, e.rdata);
                    end
                end
            end
        end
        n_checks++;
        if (dones != 4 || grants != 4) begin
            n_fail++; $display("FAIL rr_count: grants %0d dones %0d required 4 4", grants, dones);
        end
        @(negedge clk);
    endtask

    task automatic test_not_ready();
        int cyc; logic found; exp_t e;
        busy_len = 0;
        dbus.bus_ready = 1'b0;
        dbus.m0_req = 1'b1; dbus.m0_we = 1'b0; dbus.m0_size = SZ_HALF; dbus.m0_addr = 32'h40;
        sb.push_back('{mst: MST_CORE, rdata: model_rdata(32'h40), err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (dbus.m0_gnt !== 1'b0 || dbus.bus_rd !== 1'b0) begin
                n_fail++; $display("FAIL nr_no_gnt: cycle %0d gnt %b rd %b required 0 0", i, dbus.m0_gnt, dbus.bus_rd);
            end
        end
        dbus.bus_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dbus.m0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL nr_gnt: gnt %b required 1", dbus.m0_gnt);
        end
        dbus.m0_req = 1'b0;
        wait_done(10, cyc, found);
        n_checks++;
        if (!found || sb.size() == 0) begin
            n_fail++; $display("FAIL nr_done: found %b required 1", found);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (dbus.m0_done !== 1'b1 || dbus.m0_rdata !== e.rdata) begin
                n_fail++; $display("FAIL nr_result: done %b rdata %h required 1 %h", dbus.m0_done, dbus.m0_rdata, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc; logic found; exp_t e;
        busy_len = 0;
        bus_stuck = 1'b1;
        dbus.m0_req = 1'b1; dbus.m0_we = 1'b0; dbus.m0_size = SZ_WORD; dbus.m0_addr = 32'h30;
        @(negedge clk);
        dbus.m0_req = 1'b0;
        @(negedge clk);
`ifdef RISCUIN_BUS_TIMEOUT_EN
        sb.push_back('{mst: MST_CORE, rdata: 32'h0, err: 1'b1});
        wait_done(12, cyc, found);
        n_checks++;
        if (!found || cyc != 4) begin
            n_fail++; $display("FAIL to_latency: done after %0d cycles (found %b) required 4", cyc, found);
        end
        bus_stuck = 1'b0;
`else
        wait_done(12, cyc, found);
        n_checks++;
        if (found || dbus.m0_err !== 1'b0 || dbus.m1_err !== 1'b0) begin
            n_fail++; $display("FAIL to_stall: found %b err %b%b required 0 00", found, dbus.m1_err, dbus.m0_err);
        end
        sb.push_back('{mst: MST_CORE, rdata: model_rdata(32'h30), err: 1'b0});
        bus_stuck = 1'b0;
        wait_done(10, cyc, found);
`endif
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (dbus.m0_done !== 1'b1 || dbus.m0_err !== e.err || dbus.m0_rdata !== e.rdata) begin
                n_fail++; $display("FAIL to_result: done %b err %b rdata %h required 1 %b %h", dbus.m0_done, dbus.m0_err, dbus.m0_rdata, e.err, e.rdata);
            end
        end else begin
            n_checks++; n_fail++;
            $display("FAIL to_done: no completion seen, required one");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int cyc; logic found; exp_t e;
        busy_len = 0;
        bus_stuck = 1'b1;
        dbus.m0_req = 1'b1; dbus.m0_we = 1'b0; dbus.m0_size = SZ_WORD; dbus.m0_addr = 32'h50;
        @(negedge clk);
        dbus.m0_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dbus.m0_done !== 1'b0 || dbus.bus_rd !== 1'b0) begin
            n_fail++; $display("FAIL rw_in_wait: done %b rd %b required 0 0", dbus.m0_done, dbus.bus_rd);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dbus.bus_wd, dbus.bus_rd, dbus.m1_done, dbus.m0_done, dbus.m1_err, dbus.m0_err, dbus.m1_gnt, dbus.m0_gnt} !== 8'h00) begin
            n_fail++; $display("FAIL rw_after_rst: ctrl %b required 00000000", {dbus.bus_wd, dbus.bus_rd, dbus.m1_done, dbus.m0_done, dbus.m1_err, dbus.m0_err, dbus.m1_gnt, dbus.m0_gnt});
        end
        rst = 1'b0;
        bus_stuck = 1'b0;
        dbus.m1_req = 1'b1; dbus.m1_we = 1'b1; dbus.m1_size = SZ_HALF;
        dbus.m1_addr = 32'h60; dbus.m1_wdata = 32'hCAFE_F00D;
        sb.push_back('{mst: MST_EXT, rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        n_checks++;
        if (dbus.m1_gnt !== 1'b1 || dbus.bus_wd !== 1'b1 || dbus.bus_wdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL rw_regrant: gnt %b wd %b wdata %h required 1 1 cafef00d", dbus.m1_gnt, dbus.bus_wd, dbus.bus_wdata);
        end
        dbus.m1_req = 1'b0;
        wait_done(12, cyc, found);
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({dbus.m1_done, dbus.m0_done} !== (e.mst ? 2'b10 : 2'b01) || dbus.m1_rdata !== e.rdata || dbus.m1_err !== e.err) begin
                n_fail++; $display("FAIL rw_result: done %b rdata %h err %b required %b %h %b", {dbus.m1_done, dbus.m0_done}, dbus.m1_rdata, dbus.m1_err, (e.mst ? 2'b10 : 2'b01), e.rdata, e.err);
            end
        end else begin
            n_checks++; n_fail++;
            $display("FAIL rw_done: no completion seen, required one");
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        dbus.m0_req = 1'b0; dbus.m0_we = 1'b0; dbus.m0_size = 2'b00; dbus.m0_addr = '0; dbus.m0_wdata = '0;
        dbus.m1_req = 1'b0; dbus.m1_we = 1'b0; dbus.m1_size = 2'b00; dbus.m1_addr = '0; dbus.m1_wdata = '0;
        dbus.bus_ready = 1'b1; dbus.bus_busy = 1'b0; dbus.bus_rdata = '0;
        @(negedge clk);
        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin();
        test_not_ready();
        test_timeout();
        test_reset_in_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
